// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave controller: FSM state encoding,
// SDA driver mode encoding and the byte length used by the bit counter.
package i2c_pkg;

    localparam logic [3:0] BITS_PER_BYTE = 4'd8;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_CHK,
        ADDR_ACK,
        NACK_WAIT,
        TX_LOAD,
        TX_BYTE,
        TX_ACK,
        RX_BYTE,
        RX_ACK,
        RX_STORE
    } state_t;

    typedef enum logic [1:0] {
        SDA_RELEASE = 2'b00,
        SDA_LOW     = 2'b01,
        SDA_HIGH    = 2'b10,
        SDA_TX      = 2'b11
    } sda_mode_t;

endpackage

// File: rtl/i2c_bit_counter.sv
// SCL rising-edge counter for one I2C byte frame (8 data bits + ACK).
// Counts 0..8 and wraps 8 -> 0 on the ACK-bit rising edge.
//   clk, rst         : system clock, async active-high reset
//   i_clear          : synchronous clear (bus START)
//   i_count_enable   : SCL rising-edge strobe
//   o_count          : current bit count
//   o_rollover       : high in the cycle the 9th edge wraps the count
module i2c_bit_counter
    import i2c_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_count_enable,
    output logic [3:0] o_count,
    output logic       o_rollover
);

    logic [3:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_enable) begin
            r_count <= (r_count == BITS_PER_BYTE) ? 4'd0 : r_count + 4'd1;
        end
    end

    assign o_count    = r_count;
    assign o_rollover = i_count_enable && !i_clear && (r_count == BITS_PER_BYTE);

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C slave protocol controller. Consumes pre-detected SCL edge and bus
// START/STOP strobes, steers the external RX/TX shifters and FIFOs, and
// selects the SDA driver mode.
//   clk, rst                   : system clock, async active-high reset
//   rising/falling_edge_found  : SCL edge strobes
//   start_found, stop_found    : bus condition strobes (START wins)
//   rx_data                    : RX shifter contents, MSB first
//   tx_empty, sda_in           : TX FIFO empty flag, synchronized SDA
//   rx_enable, tx_enable       : shifter enables
//   load_data, tx_read         : TX shifter load / TX FIFO pop
//   rx_write                   : RX FIFO push
//   sda_mode                   : 00 release, 01 low, 10 high, 11 TX bit
//   busy                       : slave addressed, until STOP/repeated START
//
// state     | meaning
// IDLE      | bus idle or not yet started
// ADDR      | shifting in address + R/W
// ADDR_CHK  | compare address, latch R/W
// ADDR_ACK  | drive address ACK during 9th bit
// NACK_WAIT | not for us (or NACKed); wait for START/STOP
// TX_LOAD   | load TX shifter, pop TX FIFO
// TX_BYTE   | drive 8 data bits to master
// TX_ACK    | release SDA, sample master ACK
// RX_BYTE   | shift in 8 data bits
// RX_STORE  | push received byte
// RX_ACK    | drive data ACK during 9th bit
module i2c_slave_ctrl
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h1E
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rising_edge_found,
    input  logic       falling_edge_found,
    input  logic       start_found,
    input  logic       stop_found,
    input  logic [7:0] rx_data,
    input  logic       tx_empty,
    input  logic       sda_in,
    output logic       rx_enable,
    output logic       tx_enable,
    output logic       load_data,
    output logic       tx_read,
    output logic       rx_write,
    output logic [1:0] sda_mode,
    output logic       busy
);

    localparam logic [3:0] LAST_DATA_BIT = BITS_PER_BYTE - 4'd1;

    state_t    r_state, w_state_nxt;
    logic      r_phase, w_phase_nxt;
    logic      r_rw, w_rw_nxt;
    logic      r_tx_enable;
    logic      r_busy;
    logic [3:0] w_count;
    logic      w_rollover;
    logic      w_rx_enable, w_load, w_rx_write;
    sda_mode_t w_sda_mode;

    i2c_bit_counter u_bit_counter (
        .clk            (clk),
        .rst            (rst),
        .i_clear        (start_found),
        .i_count_enable (rising_edge_found),
        .o_count        (w_count),
        .o_rollover     (w_rollover)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_phase <= 1'b0;
            r_rw    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_rw    <= w_rw_nxt;
        end
    end

    // r_phase: in ADDR_ACK/RX_ACK it means "ACK is being driven";
    // in TX_ACK it means "master ACKed and more data is available".
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_rw_nxt    = r_rw;
        if (start_found) begin
            w_state_nxt = ADDR;
        end else if (stop_found) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                ADDR: begin
                    if (rising_edge_found && w_count == LAST_DATA_BIT)
                        w_state_nxt = ADDR_CHK;
                end
                ADDR_CHK: begin
                    w_rw_nxt = rx_data[0];
                    if (rx_data[7:1] == SLAVE_ADDR && !(rx_data[0] && tx_empty))
                        w_state_nxt = ADDR_ACK;
                    else
                        w_state_nxt = NACK_WAIT;
                end
                ADDR_ACK, RX_ACK: begin
                    // count==8: falling edge opening the ACK bit;
                    // count==0: falling edge closing it (after the wrap)
                    if (falling_edge_found) begin
                        if (w_count == BITS_PER_BYTE) begin
                            w_phase_nxt = 1'b1;
                        end else if (r_phase && w_count == 4'd0) begin
                            if (r_state == ADDR_ACK && r_rw)
                                w_state_nxt = TX_LOAD;
                            else
                                w_state_nxt = RX_BYTE;
                        end
                    end
                end
                TX_LOAD: w_state_nxt = TX_BYTE;
                TX_BYTE: begin
                    if (falling_edge_found && w_count == BITS_PER_BYTE)
                        w_state_nxt = TX_ACK;
                end
                TX_ACK: begin
                    if (w_rollover) begin
                        if (!sda_in && !tx_empty)
                            w_phase_nxt = 1'b1;
                        else
                            w_state_nxt = NACK_WAIT;
                    end else if (falling_edge_found && r_phase) begin
                        w_state_nxt = TX_LOAD;
                    end
                end
                RX_BYTE: begin
                    if (rising_edge_found && w_count == LAST_DATA_BIT)
                        w_state_nxt = RX_STORE;
                end
                RX_STORE: w_state_nxt = RX_ACK;
                default: ;
            endcase
        end
        if (w_state_nxt != r_state)
            w_phase_nxt = 1'b0;
    end

    // Shift the TX shifter after the falling edges of bits 1..7; bit 0 is
    // presented straight from the load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_enable <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_tx_enable <= (r_state == TX_BYTE) && falling_edge_found &&
                           !start_found && !stop_found &&
                           (w_count != 4'd0) && (w_count < BITS_PER_BYTE);
            if (start_found || stop_found)
                r_busy <= 1'b0;
            else if (r_state == ADDR_CHK && w_state_nxt == ADDR_ACK)
                r_busy <= 1'b1;
        end
    end

    always_comb begin
        w_rx_enable = 1'b0;
        w_load      = 1'b0;
        w_rx_write  = 1'b0;
        w_sda_mode  = SDA_RELEASE;
        case (r_state)
            ADDR:             w_rx_enable = 1'b1;
            ADDR_ACK, RX_ACK: if (r_phase) w_sda_mode = SDA_LOW;
            TX_LOAD: begin
                w_load     = 1'b1;
                w_sda_mode = SDA_TX;
            end
            TX_BYTE:          w_sda_mode = SDA_TX;
            RX_BYTE:          w_rx_enable = 1'b1;
            RX_STORE:         w_rx_write = 1'b1;
            default: ;
        endcase
    end

    assign rx_enable = w_rx_enable;
    assign tx_enable = r_tx_enable;
    assign load_data = w_load;
    assign tx_read   = w_load;
    assign rx_write  = w_rx_write;
    assign sda_mode  = w_sda_mode;
    assign busy      = r_busy;

endmodule
